// File: rtl/piso_pkg.sv
// Shared types and sizing helpers for the parallel-in/serial-out serializer.
package piso_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    function automatic int cnt_width(input int width);
        int c;
        c = $clog2(width);
        return (c < 1) ? 1 : c;
    endfunction

endpackage

// File: rtl/piso_bit_counter.sv
// Bit-position counter for one serialized word; saturates at WIDTH-1 until cleared.
module piso_bit_counter
    import piso_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                        CLK,
    input  logic                        i_clear,
    input  logic                        i_en,
    output logic [cnt_width(WIDTH)-1:0] o_count,
    output logic                        o_last
);

    localparam int            CW   = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge CLK) begin
        if (i_clear) begin
            r_count <= '0;
        end else if (i_en && !o_last) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_last  = (r_count == LAST);

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer: one word per WIDTH clocks over valid/ready,
// registered serial bit with per-bit valid and end-of-word marker, no gap between words.
module piso_serializer
    import piso_pkg::*;
#(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] I,
    input  logic             I_valid,
    output logic             I_ready,
    output logic             O,
    output logic             O_valid,
    output logic             O_last
);

    localparam int            CW     = cnt_width(WIDTH);
    localparam logic [CW-1:0] PENULT = CW'(WIDTH - 2);

    state_t           r_state;
    logic [WIDTH-1:0] r_sr;
    logic             r_o;
    logic             r_o_valid;
    logic             r_o_last;

    logic [CW-1:0]    w_cnt;
    logic             w_cnt_last;
    logic             w_accept;
    logic             w_cnt_clear;
    logic             w_cnt_en;
    logic             w_first_bit;
    logic             w_next_bit;
    logic [WIDTH-1:0] w_load;
    logic [WIDTH-1:0] w_shifted;

    // Ready never looks at I_valid, so there is no combinational path back to the source.
    assign I_ready  = !RESET && ((r_state == IDLE) || ((r_state == SHIFT) && w_cnt_last));
    assign w_accept = I_valid && I_ready;

    assign w_cnt_clear = RESET || w_accept || ((r_state == SHIFT) && w_cnt_last);
    assign w_cnt_en    = (r_state == SHIFT);

    piso_bit_counter #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .CLK     (CLK),
        .i_clear (w_cnt_clear),
        .i_en    (w_cnt_en),
        .o_count (w_cnt),
        .o_last  (w_cnt_last)
    );

    // The first bit bypasses sr straight to O, so sr only ever holds the remaining WIDTH-1 bits.
    always_comb begin
        if (LSB_FIRST) begin
            w_first_bit = I[0];
            w_load      = I >> 1;
            w_next_bit  = r_sr[0];
            w_shifted   = r_sr >> 1;
        end else begin
            w_first_bit = I[WIDTH-1];
            w_load      = I << 1;
            w_next_bit  = r_sr[WIDTH-1];
            w_shifted   = r_sr << 1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= IDLE;
            r_sr      <= '0;
            r_o       <= 1'b0;
            r_o_valid <= 1'b0;
            r_o_last  <= 1'b0;
        end else if (w_accept) begin
            r_state   <= SHIFT;
            r_sr      <= w_load;
            r_o       <= w_first_bit;
            r_o_valid <= 1'b1;
            r_o_last  <= 1'b0;
        end else begin
            case (r_state)
                SHIFT: begin
                    if (!w_cnt_last) begin
                        r_o      <= w_next_bit;
                        r_sr     <= w_shifted;
                        r_o_last <= (w_cnt == PENULT);
                    end else begin
                        r_state   <= IDLE;
                        r_o       <= 1'b0;
                        r_o_valid <= 1'b0;
                        r_o_last  <= 1'b0;
                    end
                end
                default: begin
                    r_o       <= 1'b0;
                    r_o_valid <= 1'b0;
                    r_o_last  <= 1'b0;
                end
            endcase
        end
    end

    assign O       = r_o;
    assign O_valid = r_o_valid;
    assign O_last  = r_o_last;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: four configurations checked every cycle against a pending-bit queue model.
module tb_piso_serializer;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [3:0][7:0] wd;
    logic [3:0]      iv;
    logic [3:0]      rs;
    logic [3:0]      rdy;
    logic [3:0]      so;
    logic [3:0]      sv;
    logic [3:0]      sl;

    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_w4l (
        .CLK(CLK), .RESET(rs[0]), .I(wd[0][3:0]), .I_valid(iv[0]),
        .I_ready(rdy[0]), .O(so[0]), .O_valid(sv[0]), .O_last(sl[0]));
    piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) u_w4m (
        .CLK(CLK), .RESET(rs[1]), .I(wd[1][3:0]), .I_valid(iv[1]),
        .I_ready(rdy[1]), .O(so[1]), .O_valid(sv[1]), .O_last(sl[1]));
    piso_serializer #(.WIDTH(2), .LSB_FIRST(1'b1)) u_w2 (
        .CLK(CLK), .RESET(rs[2]), .I(wd[2][1:0]), .I_valid(iv[2]),
        .I_ready(rdy[2]), .O(so[2]), .O_valid(sv[2]), .O_last(sl[2]));
    piso_serializer #(.WIDTH(8), .LSB_FIRST(1'b0)) u_w8 (
        .CLK(CLK), .RESET(rs[3]), .I(wd[3]), .I_valid(iv[3]),
        .I_ready(rdy[3]), .O(so[3]), .O_valid(sv[3]), .O_last(sl[3]));

    function automatic int wof(input int n);
        case (n)
            2:       return 2;
            3:       return 8;
            default: return 4;
        endcase
    endfunction

    function automatic bit lsbof(input int n);
        return (n == 0) || (n == 2);
    endfunction

    // Reference model: each accepted word becomes a queue of pending bits popped one per cycle.
    int          pn [4];
    logic [63:0] pb [4];
    logic [63:0] pl [4];
    logic [7:0]  accw [4];
    logic [3:0]  eo, ev, el;
    int          cyc;
    bit          chk_en;

    initial begin
        cyc    = 0;
        chk_en = 1'b0;
        eo = '0; ev = '0; el = '0;
        for (int n = 0; n < 4; n++) begin
            pn[n] = 0; pb[n] = '0; pl[n] = '0; accw[n] = '0;
        end
        forever begin
            @(posedge CLK);
            cyc++;
            chk_en = 1'b1;
            for (int n = 0; n < 4; n++) begin
                int w;
                w = wof(n);
                if (rs[n]) begin
                    pn[n] = 0; pb[n] = '0; pl[n] = '0;
                end else if (iv[n] && pn[n] == 0) begin
                    pb[n] = '0;
                    for (int j = 0; j < w; j++)
                        pb[n][j] = lsbof(n) ? wd[n][j] : wd[n][w-1-j];
                    pl[n]   = 64'd1 << (w - 1);
                    pn[n]   = w;
                    accw[n] = wd[n] & 8'((1 << w) - 1);
                end
                if (pn[n] > 0) begin
                    eo[n] = pb[n][0]; ev[n] = 1'b1; el[n] = pl[n][0];
                    pb[n] = pb[n] >> 1; pl[n] = pl[n] >> 1; pn[n]--;
                end else begin
                    eo[n] = 1'b0; ev[n] = 1'b0; el[n] = 1'b0;
                end
            end
        end
    end

    // Compare process, plus capture of the emitted stream and a SISO rebuild of each word.
    int          m_cmp, m_err;
    logic [63:0] cap [4];
    int          cn [4], lc [4], fc [4], lcy [4], prevl [4], lgap [4];
    logic [7:0]  siso [4];
    int          clr_req = 0;
    int          clr_seen;

    initial begin
        m_cmp = 0; m_err = 0; clr_seen = 0;
        for (int n = 0; n < 4; n++) begin
            cap[n] = '0; cn[n] = 0; lc[n] = 0; fc[n] = -1; lcy[n] = -1;
            prevl[n] = -1; lgap[n] = 0; siso[n] = '0;
        end
        forever begin
            @(negedge CLK);
            if (clr_req != clr_seen) begin
                for (int n = 0; n < 4; n++) begin
                    cap[n] = '0; cn[n] = 0; lc[n] = 0; fc[n] = -1; lcy[n] = -1;
                    prevl[n] = -1; lgap[n] = 0;
                end
                clr_seen = clr_req;
            end
            if (chk_en) begin
                for (int n = 0; n < 4; n++) begin
                    logic er;
                    int   w;
                    w  = wof(n);
                    er = !rs[n] && (pn[n] == 0);
                    m_cmp++;
                    if ({so[n], sv[n], sl[n], rdy[n]} !== {eo[n], ev[n], el[n], er}) begin
                        m_err++;
                        $display("FAIL outputs inst%0d cyc%0d: O/valid/last/ready got %b%b%b%b want %b%b%b%b",
                                 n, cyc, so[n], sv[n], sl[n], rdy[n], eo[n], ev[n], el[n], er);
                    end
                    if (sv[n] === 1'b1) begin
                        if (cn[n] < 64) cap[n][cn[n]] = so[n];
                        cn[n]++;
                        if (fc[n] < 0) fc[n] = cyc;
                        lcy[n] = cyc;
                        if (lsbof(n)) siso[n] = (siso[n] >> 1) | (8'(so[n]) << (w - 1));
                        else          siso[n] = ((siso[n] << 1) | 8'(so[n])) & 8'((1 << w) - 1);
                    end
                    if (sl[n] === 1'b1) begin
                        lc[n]++;
                        if (prevl[n] >= 0) lgap[n] = cyc - prevl[n];
                        prevl[n] = cyc;
                        m_cmp++;
                        if (siso[n] !== accw[n]) begin
                            m_err++;
                            $display("FAIL siso_word inst%0d cyc%0d: got %h want %h", n, cyc, siso[n], accw[n]);
                        end
                    end
                end
            end
        end
    end

    int d_cmp = 0;
    int d_err = 0;

    task automatic chk(input string nm, input int act, input int exp);
        d_cmp++;
        if (act != exp) begin
            d_err++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic clr();
        clr_req++;
    endtask

    task automatic send(input int n, input logic [7:0] word);
        logic r;
        bit   got;
        got = 1'b0;
        wd[n] = word;
        iv[n] = 1'b1;
        for (int t = 0; t < 40; t++) begin
            @(negedge CLK);
            r = rdy[n];
            @(posedge CLK);
            #1;
            if (r) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            d_err++;
            d_cmp++;
            $display("FAIL send_timeout inst%0d: got no accept want accept within 40 cycles", n);
        end
    endtask

    initial begin
        rs = '1; iv = '1; wd = '0;

        // Reset held three edges with I_valid high.
        @(posedge CLK);
        repeat (2) begin
            @(negedge CLK);
            chk("ready_in_reset", int'(rdy[0]), 0);
            chk("valid_in_reset", int'(sv[0]), 0);
            @(posedge CLK);
        end
        #1;
        rs = '0; iv = '0;
        @(negedge CLK);
        chk("ready_after_reset", int'(rdy[0]), 1);

        // Single word 1011, LSB first.
        @(posedge CLK); #1;
        clr();
        send(0, 8'hB);
        iv[0] = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        chk("single_bits", int'(cap[0][3:0]), 'hB);
        chk("single_valid_count", cn[0], 4);
        chk("single_last_count", lc[0], 1);
        chk("single_span", lcy[0] - fc[0] + 1, 4);

        // Back-to-back A then 5, MSB first.
        clr();
        send(1, 8'hA);
        send(1, 8'h5);
        iv[1] = 1'b0;
        repeat (10) @(posedge CLK);
        #1;
        chk("b2b_bits", int'(cap[1][7:0]), 'hA5);
        chk("b2b_valid_count", cn[1], 8);
        chk("b2b_span", lcy[1] - fc[1] + 1, 8);
        chk("b2b_last_count", lc[1], 2);
        chk("b2b_last_gap", lgap[1], 4);

        // F, idle, then 0.
        clr();
        send(0, 8'hF);
        iv[0] = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        send(0, 8'h0);
        iv[0] = 1'b0;
        repeat (8) @(posedge CLK);
        #1;
        chk("gap_bits", int'(cap[0][7:0]), 'h0F);
        chk("gap_valid_count", cn[0], 8);
        chk("gap_span", lcy[0] - fc[0] + 1, 11);

        // Reset during the second bit of C.
        clr();
        send(0, 8'hC);
        iv[0] = 1'b0;
        @(posedge CLK); #1;
        rs[0] = 1'b1;
        @(posedge CLK); #1;
        rs[0] = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        chk("rst_mid_valid_count", cn[0], 2);
        chk("rst_mid_last_count", lc[0], 0);
        clr();
        send(0, 8'h6);
        iv[0] = 1'b0;
        repeat (6) @(posedge CLK);
        #1;
        chk("after_rst_bits", int'(cap[0][3:0]), 'h6);
        chk("after_rst_valid_count", cn[0], 4);

        // Random words, random valid, occasional reset on every configuration.
        for (int c = 0; c < 800; c++) begin
            for (int n = 0; n < 4; n++) begin
                iv[n] = ($urandom_range(0, 3) != 0);
                wd[n] = 8'($urandom);
                rs[n] = ($urandom_range(0, 59) == 0);
            end
            @(posedge CLK);
            #1;
        end
        rs = '0; iv = '0;
        repeat (12) @(posedge CLK);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", d_cmp + m_cmp, d_err + m_err);
        $finish;
    end

endmodule
